// File: rtl/huffman_pkg.sv
// Shared constants for the Huffman frame controller: default frame geometry,
// watchdog limit and FSM state encoding.
package huffman_pkg;

  localparam int HUF_N_SYM   = 10;
  localparam int HUF_FREQ_W  = 8;
  localparam int HUF_CODE_W  = 13;
  localparam int HUF_TIMEOUT = 1024;
  localparam int IDX_W       = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_BUILD = 3'd2;
  localparam logic [2:0] ST_CODE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/huffman_if.sv
// Frame bus between the controller (slave) and its environment (master):
// frequency load, builder/generator handshakes, code drain and status.
interface huffman_if
  import huffman_pkg::*;
#(
  parameter int N_SYM  = HUF_N_SYM,
  parameter int FREQ_W = HUF_FREQ_W,
  parameter int CODE_W = HUF_CODE_W
);
  logic                      In_valid;
  logic [FREQ_W-1:0]         In_data;
  logic                      In_ready;
  logic [N_SYM*FREQ_W-1:0]   Freq_bus;
  logic                      Build_start;
  logic                      Build_done;
  logic                      Start_code;
  logic                      Fin;
  logic [N_SYM*CODE_W-1:0]   Codes_bus;
  logic                      Out_valid;
  logic [IDX_W-1:0]          Out_sym;
  logic [CODE_W-1:0]         Out_code;
  logic                      Out_ready;
  logic                      Clear;
  logic                      Busy;
  logic                      Done;
  logic                      Err;

  modport master (
    output In_valid, In_data, Build_done, Fin, Codes_bus, Out_ready, Clear,
    input  In_ready, Freq_bus, Build_start, Start_code, Out_valid, Out_sym,
           Out_code, Busy, Done, Err
  );

  modport slave (
    input  In_valid, In_data, Build_done, Fin, Codes_bus, Out_ready, Clear,
    output In_ready, Freq_bus, Build_start, Start_code, Out_valid, Out_sym,
           Out_code, Busy, Done, Err
  );

endinterface

// File: rtl/huffman_wdog.sv
// Cycle watchdog: counts while en, restarts on clr, flags the terminal count
// combinationally so the owner can leave on the following edge.
module huffman_wdog
  import huffman_pkg::*;
#(
  parameter int TIMEOUT = HUF_TIMEOUT
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/huffman_ctrl.sv
// Huffman frame controller: loads N_SYM frequencies, sequences tree build and
// code generation under a watchdog, then drains codes one beat per Out_ready.
module huffman_ctrl
  import huffman_pkg::*;
#(
  parameter int N_SYM   = HUF_N_SYM,
  parameter int FREQ_W  = HUF_FREQ_W,
  parameter int CODE_W  = HUF_CODE_W,
  parameter int TIMEOUT = HUF_TIMEOUT
)(
  input  logic     Clk_in,
  input  logic     n_Rst,
  huffman_if.slave bus
);

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        load_idx_q, load_idx_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic [N_SYM*FREQ_W-1:0] freq_q;
  logic [N_SYM*CODE_W-1:0] code_q;
  logic                    rdy_en_q;
  logic                    build_start_q;
  logic                    done_q, done_d;
  logic                    freq_we, code_we;
  logic                    in_rdy;
  logic                    wd_clr, wd_en, wd_exp;
  logic [CODE_W-1:0]       out_code;

  // rdy_en_q keeps In_ready low while reset is held, even though state is IDLE
  assign in_rdy = rdy_en_q && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign wd_en  = (state_q == ST_BUILD) || (state_q == ST_CODE);
  assign wd_clr = (state_d != state_q) && (state_d == ST_BUILD || state_d == ST_CODE);

  huffman_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (Clk_in),
    .rst_n   (n_Rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_exp)
  );

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    out_idx_d  = out_idx_q;
    done_d     = 1'b0;
    freq_we    = 1'b0;
    code_we    = 1'b0;
    if (bus.Clear) begin
      state_d    = ST_IDLE;
      load_idx_d = '0;
      out_idx_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (bus.In_valid && in_rdy) begin
            freq_we = 1'b1;
            if (load_idx_q == IDX_W'(N_SYM - 1)) begin
              state_d    = ST_BUILD;
              load_idx_d = '0;
            end else begin
              state_d    = ST_LOAD;
              load_idx_d = load_idx_q + 1'b1;
            end
          end
        end
        ST_BUILD: begin
          // completion beats a simultaneous watchdog expiry
          if (bus.Build_done)
            state_d = ST_CODE;
          else if (wd_exp)
            state_d = ST_ERR;
        end
        ST_CODE: begin
          if (bus.Fin) begin
            code_we = 1'b1;
            state_d = ST_DRAIN;
          end else if (wd_exp) begin
            state_d = ST_ERR;
          end
        end
        ST_DRAIN: begin
          if (bus.Out_ready) begin
            if (out_idx_q == IDX_W'(N_SYM - 1)) begin
              state_d   = ST_IDLE;
              out_idx_d = '0;
              done_d    = 1'b1;
            end else begin
              out_idx_d = out_idx_q + 1'b1;
            end
          end
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state_q       <= ST_IDLE;
      load_idx_q    <= '0;
      out_idx_q     <= '0;
      freq_q        <= '0;
      code_q        <= '0;
      rdy_en_q      <= 1'b0;
      build_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_idx_q    <= load_idx_d;
      out_idx_q     <= out_idx_d;
      rdy_en_q      <= 1'b1;
      build_start_q <= (state_d == ST_BUILD) && (state_q != ST_BUILD);
      done_q        <= done_d;
      if (freq_we) begin
        for (int k = 0; k < N_SYM; k++) begin
          if (load_idx_q == IDX_W'(k))
            freq_q[k*FREQ_W +: FREQ_W] <= bus.In_data;
        end
      end
      if (code_we)
        code_q <= bus.Codes_bus;
    end
  end

  always_comb begin
    out_code = '0;
    for (int k = 0; k < N_SYM; k++) begin
      if (out_idx_q == IDX_W'(k))
        out_code = code_q[k*CODE_W +: CODE_W];
    end
  end

  assign bus.In_ready    = in_rdy;
  assign bus.Freq_bus    = freq_q;
  assign bus.Build_start = build_start_q;
  assign bus.Start_code  = (state_q == ST_CODE);
  assign bus.Out_valid   = (state_q == ST_DRAIN);
  assign bus.Out_sym     = out_idx_q;
  assign bus.Out_code    = out_code;
  assign bus.Busy        = (state_q != ST_IDLE);
  assign bus.Done        = done_q;
  assign bus.Err         = (state_q == ST_ERR);

endmodule

// File: tb/tb_huffman_ctrl.sv
// Directed bench for huffman_ctrl: load, build, code, drain, watchdog expiry,
// done-versus-expiry race and mid-drain reset.
module tb_huffman_ctrl;

  logic Clk_in = 1'b0;
  logic n_Rst  = 1'b0;
  always #5 Clk_in = ~Clk_in;

  huffman_if #(.N_SYM(10), .FREQ_W(8), .CODE_W(13)) bus ();

  huffman_ctrl #(.N_SYM(10), .FREQ_W(8), .CODE_W(13), .TIMEOUT(1024)) dut (
    .Clk_in (Clk_in),
    .n_Rst  (n_Rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  fa [10] = '{8'd53, 8'd40, 8'd26, 8'd14, 8'd38, 8'd23, 8'd7, 8'd12, 8'd4, 8'd39};
  logic [7:0]  fb [10] = '{8'd0, 8'd255, 8'd1, 8'd128, 8'd0, 8'd17, 8'd99, 8'd200, 8'd3, 8'd64};
  logic [12:0] ct [10] = '{13'h1FFF, 13'h0001, 13'h0AAA, 13'h1555, 13'h0123,
                           13'h1234, 13'h0F0F, 13'h10F0, 13'h0042, 13'h1801};
  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // {In_ready, Build_start, Start_code, Out_valid, Busy, Done, Err}
  wire [6:0] flags = {bus.In_ready, bus.Build_start, bus.Start_code, bus.Out_valid,
                      bus.Busy, bus.Done, bus.Err};

  function automatic logic [79:0] pack_freq(input int which);
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = (which == 1) ? fb[i] : fa[i];
    return v;
  endfunction

  function automatic logic [129:0] pack_codes();
    logic [129:0] v;
    for (int i = 0; i < 10; i++) v[i*13 +: 13] = ct[i];
    return v;
  endfunction

  task automatic step();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic drive_frame(input int which);
    for (int i = 0; i < 10; i++) begin
      bus.In_valid = 1'b1;
      bus.In_data  = (which == 1) ? fb[i] : fa[i];
      step();
    end
    bus.In_valid = 1'b0;
    bus.In_data  = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (flags !== 7'b0) begin failures++; $display("FAIL reset_flags: got %b want 0000000", flags); end
    checks++; if (bus.Freq_bus !== 80'd0) begin failures++; $display("FAIL reset_freq: got %h want 0", bus.Freq_bus); end
    checks++; if ({bus.Out_sym, bus.Out_code} !== 17'd0) begin failures++; $display("FAIL reset_out: got %h want 0", {bus.Out_sym, bus.Out_code}); end
    step(); step();
    checks++; if (bus.In_ready !== 1'b0) begin failures++; $display("FAIL reset_held_ready: got %b want 0", bus.In_ready); end
    n_Rst = 1'b1;
    #1;
    checks++; if (bus.In_ready !== 1'b0) begin failures++; $display("FAIL release_before_edge: got %b want 0", bus.In_ready); end
    step();
    checks++; if (flags !== 7'b1000000) begin failures++; $display("FAIL release_ready: got %b want 1000000", flags); end
  endtask

  task automatic test_load();
    int not_rdy = 0;
    int bs_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      bus.In_valid = 1'b1;
      bus.In_data  = fa[i];
      if (bus.In_ready !== 1'b1) not_rdy++;
      step();
    end
    bus.In_valid = 1'b0;
    checks++; if (not_rdy != 0) begin failures++; $display("FAIL load_ready: %0d beats saw In_ready low, want 0", not_rdy); end
    checks++; if (flags !== 7'b0100100) begin failures++; $display("FAIL load_to_build: got %b want 0100100", flags); end
    checks++; if (bus.Freq_bus[7:0] !== 8'd53) begin failures++; $display("FAIL freq_slot0: got %0d want 53", bus.Freq_bus[7:0]); end
    checks++; if (bus.Freq_bus[79:72] !== 8'd39) begin failures++; $display("FAIL freq_slot9: got %0d want 39", bus.Freq_bus[79:72]); end
    checks++; if (bus.Freq_bus !== pack_freq(0)) begin failures++; $display("FAIL freq_all: got %h want %h", bus.Freq_bus, pack_freq(0)); end
    for (int i = 0; i < 19; i++) begin
      step();
      if (bus.Build_start !== 1'b0) bs_cnt++;
    end
    checks++; if (bs_cnt != 0) begin failures++; $display("FAIL build_start_once: extra pulses %0d want 0", bs_cnt); end
  endtask

  task automatic test_build_code();
    int bad = 0;
    step();
    checks++; if (bus.Start_code !== 1'b0) begin failures++; $display("FAIL code_before_done: got %b want 0", bus.Start_code); end
    bus.Build_done = 1'b1;
    step();
    bus.Build_done = 1'b0;
    checks++; if (flags !== 7'b0010100) begin failures++; $display("FAIL enter_code: got %b want 0010100", flags); end
    for (int i = 0; i < 29; i++) begin
      step();
      if (bus.Start_code !== 1'b1 || bus.Out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL code_hold: %0d bad cycles want 0", bad); end
    bus.Fin       = 1'b1;
    bus.Codes_bus = pack_codes();
    step();
    bus.Fin       = 1'b0;
    bus.Codes_bus = '1;
    checks++; if (flags !== 7'b0001100) begin failures++; $display("FAIL enter_drain: got %b want 0001100", flags); end
  endtask

  task automatic test_drain();
    int e = 0;
    int c = 0;
    int bad = 0;
    while (e < 10 && c < 60) begin
      bus.Out_ready = pat[c % 4];
      if ({bus.Out_valid, bus.Out_sym, bus.Out_code, bus.Done} !== {1'b1, e[3:0], ct[e], 1'b0}) begin
        bad++;
        $display("FAIL drain_beat: cycle %0d got sym %0d code %h want sym %0d code %h", c, bus.Out_sym, bus.Out_code, e, ct[e]);
      end
      step();
      if (pat[c % 4]) e++;
      c++;
    end
    bus.Out_ready = 1'b0;
    checks++; if (bad != 0 || e != 10) begin failures++; $display("FAIL drain_seq: bad %0d beats %0d want 0 and 10", bad, e); end
    checks++; if (flags !== 7'b1000010) begin failures++; $display("FAIL drain_done: got %b want 1000010", flags); end
    step();
    checks++; if (flags !== 7'b1000000) begin failures++; $display("FAIL done_single: got %b want 1000000", flags); end
  endtask

  task automatic test_timeout();
    int early = 0;
    drive_frame(0);
    for (int i = 0; i < 1023; i++) begin
      if (bus.Err !== 1'b0) early++;
      step();
    end
    checks++; if (early != 0 || bus.Err !== 1'b0) begin failures++; $display("FAIL wdog_early: got %0d early err=%b want 0", early, bus.Err); end
    step();
    checks++; if (flags !== 7'b0000101) begin failures++; $display("FAIL wdog_err: got %b want 0000101", flags); end
    bus.Build_done = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.Build_done = 1'b0;
    checks++; if (flags !== 7'b0000101) begin failures++; $display("FAIL err_sticky: got %b want 0000101", flags); end
    bus.Clear = 1'b1;
    step();
    bus.Clear = 1'b0;
    checks++; if (flags !== 7'b1000000) begin failures++; $display("FAIL clear_idle: got %b want 1000000", flags); end
    checks++; if (bus.Freq_bus !== pack_freq(0)) begin failures++; $display("FAIL clear_freq_hold: got %h want %h", bus.Freq_bus, pack_freq(0)); end
    bus.Build_done = 1'b1;
    step();
    bus.Build_done = 1'b0;
    checks++; if (flags !== 7'b1000000) begin failures++; $display("FAIL idle_ignores_done: got %b want 1000000", flags); end
  endtask

  task automatic test_race();
    drive_frame(1);
    checks++; if (bus.Freq_bus !== pack_freq(1)) begin failures++; $display("FAIL freq_zero_pass: got %h want %h", bus.Freq_bus, pack_freq(1)); end
    for (int i = 0; i < 1023; i++) step();
    bus.Build_done = 1'b1;
    step();
    bus.Build_done = 1'b0;
    checks++; if (flags !== 7'b0010100) begin failures++; $display("FAIL race_code: got %b want 0010100", flags); end
    step(); step(); step();
    checks++; if (flags !== 7'b0010100) begin failures++; $display("FAIL race_no_err: got %b want 0010100", flags); end
    bus.Fin       = 1'b1;
    bus.Codes_bus = pack_codes();
    step();
    bus.Fin = 1'b0;
    checks++; if (bus.Out_valid !== 1'b1) begin failures++; $display("FAIL race_drain: got %b want 1", bus.Out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.Out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.Out_ready = 1'b0;
    checks++; if ({bus.Out_sym, bus.Out_code} !== {4'd4, ct[4]}) begin failures++; $display("FAIL mid_idx4: got %h want %h", {bus.Out_sym, bus.Out_code}, {4'd4, ct[4]}); end
    #2;
    n_Rst = 1'b0;
    #1;
    checks++; if (flags !== 7'b0 || bus.Freq_bus !== 80'd0 || {bus.Out_sym, bus.Out_code} !== 17'd0) begin
      failures++; $display("FAIL mid_reset_zero: flags %b freq %h out %h want all 0", flags, bus.Freq_bus, {bus.Out_sym, bus.Out_code});
    end
    step(); step();
    n_Rst = 1'b1;
    step();
    checks++; if (flags !== 7'b1000000) begin failures++; $display("FAIL mid_release: got %b want 1000000", flags); end
    drive_frame(0);
    checks++; if (flags !== 7'b0100100 || bus.Freq_bus !== pack_freq(0)) begin
      failures++; $display("FAIL reload: flags %b freq %h want 0100100 %h", flags, bus.Freq_bus, pack_freq(0));
    end
    bus.Build_done = 1'b1;
    step();
    bus.Build_done = 1'b0;
    bus.Fin        = 1'b1;
    bus.Codes_bus  = pack_codes();
    step();
    bus.Fin       = 1'b0;
    bus.Out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.Out_ready = 1'b0;
    checks++; if (flags !== 7'b1000010) begin failures++; $display("FAIL reload_done: got %b want 1000010", flags); end
  endtask

  initial begin
    bus.In_valid   = 1'b0;
    bus.In_data    = '0;
    bus.Build_done = 1'b0;
    bus.Fin        = 1'b0;
    bus.Codes_bus  = '0;
    bus.Out_ready  = 1'b0;
    bus.Clear      = 1'b0;
    test_reset();
    test_load();
    test_build_code();
    test_drain();
    test_timeout();
    test_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
